// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Steps an instruction through NUM_PHASES phases (0 .. NUM_PHASES-1) and counts
// how many instructions have completed. A two-state FSM (IDLE / RUN) tracks
// whether the sequencer is running. Every output comes straight from a flop.
//
// Parameters
//   NUM_PHASES  number of instruction phases (2..16)
//   IDX_W       phase index width, 2**IDX_W >= NUM_PHASES
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset; forces IDLE at once
//   en           run enable; low sends the FSM to IDLE on the next edge
//   stall        hold the current phase
//   early_end    end the instruction after the current phase
//   ext_phase    (WAIT_STATES_EN only) phase that gets extra wait cycles
//   ext_cycles   (WAIT_STATES_EN only) extra cycles latched on entry
//   phase_oh     one-hot active phase, zero in IDLE
//   phase_idx    binary active phase, zero in IDLE
//   cycle_start  high only in the first cycle of phase 0
//   instr_cnt    completed instruction count, wraps at 16'hFFFF
//
// Optional feature: define WAIT_STATES_EN to add the wait-state counter and
// its two input ports. With it undefined every phase lasts exactly one cycle
// unless stalled.
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  early_end,
`ifdef WAIT_STATES_EN
  input  logic [IDX_W-1:0]      ext_phase,
  input  logic [3:0]            ext_cycles,
`endif
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_start,
  output logic [15:0]           instr_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(NUM_PHASES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        phase_q, phase_d;
  logic [NUM_PHASES-1:0]   phase_oh_q, phase_oh_d;
  logic                    cycle_start_q, cycle_start_d;
  logic [15:0]             instr_cnt_q, instr_cnt_d;

  // advance: a new phase is entered on this edge (phase_d names it).
  // complete: this edge finishes an instruction (wrap or early end).
  logic                    advance;
  logic                    complete;
  logic                    wait_pending;

`ifdef WAIT_STATES_EN
  logic [3:0]              wait_q, wait_d;
  assign wait_pending = (wait_q != 4'd0);
`else
  assign wait_pending = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (FSM state, phase and all registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      phase_oh_q    <= '0;
      cycle_start_q <= 1'b0;
      instr_cnt_q   <= 16'd0;
`ifdef WAIT_STATES_EN
      wait_q        <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_oh_q    <= phase_oh_d;
      cycle_start_q <= cycle_start_d;
      instr_cnt_q   <= instr_cnt_d;
`ifdef WAIT_STATES_EN
      wait_q        <= wait_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: priority en=0, stall, wait state, end of instruction,
  // plain advance.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    advance  = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stall and early_end have no meaning until the first phase runs
        if (en) begin
          state_d = ST_RUN;
          phase_d = '0;
          advance = 1'b1;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (stall || wait_pending) begin
          phase_d = phase_q;
        end else if (early_end || (phase_q == LAST_PHASE)) begin
          // early_end in the last phase is the same single completion
          phase_d  = '0;
          advance  = 1'b1;
          complete = 1'b1;
        end else begin
          phase_d = phase_q + IDX_W'(1);
          advance = 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_oh_d = '0;
    if (state_d == ST_RUN) begin
      phase_oh_d = NUM_PHASES'(1) << phase_d;
    end
    // Only a real entry into phase 0 starts an instruction; a held phase 0
    // keeps cycle_start low.
    cycle_start_d = advance && (phase_d == '0);
    instr_cnt_d   = instr_cnt_q + (complete ? 16'd1 : 16'd0);
`ifdef WAIT_STATES_EN
    if (state_d != ST_RUN) begin
      wait_d = 4'd0;
    end else if (advance) begin
      wait_d = (phase_d == ext_phase) ? ext_cycles : 4'd0;
    end else if (!stall && wait_pending) begin
      wait_d = wait_q - 4'd1;
    end else begin
      wait_d = wait_q;
    end
`endif
  end

  assign phase_oh    = phase_oh_q;
  assign phase_idx   = phase_q;
  assign cycle_start = cycle_start_q;
  assign instr_cnt   = instr_cnt_q;

endmodule
